// File: rtl/sprite_move_scheduler.sv
// sprite_move_scheduler: PS/2 scancodes -> queued box moves, one applied per video frame
module sprite_move_scheduler #(
    parameter int MOVE_STEP  = 10,
    parameter int BOX_W      = 64,
    parameter int BOX_H      = 48,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int INIT_X     = 320,
    parameter int INIT_Y     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_n,
    input  logic [7:0]                    key_in,
    input  logic                          key_en,
    input  logic                          vs_in,
    output logic [9:0]                    pos_x,
    output logic [9:0]                    pos_y,
    output logic                          upd,
    output logic [$clog2(FIFO_DEPTH):0]   q_level,
    output logic [7:0]                    drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE  = 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0] STEP  = 10'(MOVE_STEP);
    localparam logic [9:0] X_MAX = 10'(H_RES - 1 - BOX_W);
    localparam logic [9:0] Y_MAX = 10'(V_RES - 1 - BOX_H);
    localparam logic [1:0] C_UP = 2'd0, C_DOWN = 2'd1, C_LEFT = 2'd2, C_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK} state_t;

    state_t      state_q, state_d;
    logic        push_q, push_d, upd_q, upd_d, vs_q, vs_d;
    logic [1:0]  code_q, code_d, cmd;
    logic [1:0]  mem_q [FIFO_DEPTH];
    logic [1:0]  mem_d [FIFO_DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, level;
    logic [7:0]  drop_q, drop_d;
    logic [9:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [10:0] sum_x, sum_y;
    logic        is_dir, full, pop, do_wr;

    // scancode decoder: prefixes steer the state, direction makes register a push for next cycle
    always_comb begin
        is_dir  = key_in inside {8'h75, 8'h72, 8'h6B, 8'h74};
        state_d = state_q;
        push_d  = 1'b0;
        code_d  = code_q;
        if (key_en) begin
            push_d  = is_dir && state_q != S_BRK;
            code_d  = key_in == 8'h75 ? C_UP : key_in == 8'h72 ? C_DOWN :
                      key_in == 8'h6B ? C_LEFT : C_RIGHT;
            state_d = state_q == S_BRK ? S_IDLE :
                      key_in == 8'hF0 ? S_BRK :
                      (key_in == 8'hE0 && state_q == S_IDLE) ? S_EXT : S_IDLE;
        end
    end

    // command queue and frame tick: a full queue still accepts a push when a pop frees a slot
    always_comb begin
        level  = wr_q - rd_q;
        full   = level == FULL;
        vs_d   = vs_in;
        pop    = vs_q && !vs_in && level != '0;
        do_wr  = push_q && (!full || pop);
        wr_d   = do_wr ? wr_q + ONE : wr_q;
        rd_d   = pop ? rd_q + ONE : rd_q;
        drop_d = (push_q && full && !pop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        mem_d  = mem_q;
        if (do_wr)
            mem_d[wr_q[AW-1:0]] = code_q;
        cmd    = mem_q[rd_q[AW-1:0]];
        upd_d  = pop;
    end

    // clamped position update, only on a popping tick so the box holds still during active video
    always_comb begin
        sum_x   = {1'b0, pos_x_q} + {1'b0, STEP};
        sum_y   = {1'b0, pos_y_q} + {1'b0, STEP};
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (pop) begin
            pos_y_d = cmd == C_UP ? (pos_y_q < STEP ? '0 : pos_y_q - STEP) :
                      cmd == C_DOWN ? (sum_y > {1'b0, Y_MAX} ? Y_MAX : sum_y[9:0]) : pos_y_q;
            pos_x_d = cmd == C_LEFT ? (pos_x_q < STEP ? '0 : pos_x_q - STEP) :
                      cmd == C_RIGHT ? (sum_x > {1'b0, X_MAX} ? X_MAX : sum_x[9:0]) : pos_x_q;
        end
    end

    // all state; reset flushes the queue and drops any pending prefix
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= S_IDLE;
            push_q  <= 1'b0;
            code_q  <= '0;
            upd_q   <= 1'b0;
            vs_q    <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            drop_q  <= '0;
            pos_x_q <= 10'(INIT_X);
            pos_y_q <= 10'(INIT_Y);
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            code_q  <= code_d;
            upd_q   <= upd_d;
            vs_q    <= vs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            drop_q  <= drop_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            mem_q   <= mem_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign upd      = upd_q;
    assign q_level  = level;
    assign drop_cnt = drop_q;
endmodule

// File: tb/tb_sprite_move_scheduler.sv
// tb_sprite_move_scheduler: directed vectors and corner sequences for the sprite move scheduler
module tb_sprite_move_scheduler;
    logic       clk = 1'b0, rst_n = 1'b0, key_en = 1'b0, vs = 1'b1;
    logic [7:0] key = 8'h00;
    logic [9:0] pos_x, pos_y;
    logic       upd;
    logic [2:0] q_level;
    logic [7:0] drop_cnt;
    logic       u;
    int         total = 0, passed = 0;

    typedef struct {
        logic       pre;
        logic [7:0] key;
        int         lvl;
        int         x;
        int         y;
        logic       upd;
    } vec_t;
    vec_t vt[6];

    always #5 clk = ~clk;

    sprite_move_scheduler dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .key_in(key), .key_en(key_en), .vs_in(vs),
        .pos_x(pos_x), .pos_y(pos_y), .upd(upd), .q_level(q_level), .drop_cnt(drop_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        key = b;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
    endtask

    task automatic frame(output logic pulse);
        vs = 1'b0;
        @(negedge clk);
        pulse = upd;
        vs = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_x", pos_x, 320);
        check("rst_y", pos_y, 240);
        check("rst_upd", upd, 0);
        check("rst_lvl", q_level, 0);
        check("rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{1'b0, 8'h74, 1, 330, 240, 1'b1};
        vt[1] = '{1'b1, 8'h75, 1, 330, 230, 1'b1};
        vt[2] = '{1'b0, 8'h72, 1, 330, 240, 1'b1};
        vt[3] = '{1'b1, 8'h6B, 1, 320, 240, 1'b1};
        vt[4] = '{1'b1, 8'h74, 1, 330, 240, 1'b1};
        vt[5] = '{1'b0, 8'h1C, 0, 330, 240, 1'b0};
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            if (vt[i].pre) send(8'hE0);
            send(vt[i].key);
            @(negedge clk);
            check($sformatf("vec%0d_lvl", i), q_level, vt[i].lvl);
            frame(u);
            check($sformatf("vec%0d_upd", i), u, vt[i].upd);
            check($sformatf("vec%0d_x", i), pos_x, vt[i].x);
            check($sformatf("vec%0d_y", i), pos_y, vt[i].y);
            check($sformatf("vec%0d_lvl_after", i), q_level, 0);
        end

        send(8'hE0); send(8'hF0); send(8'h75);
        @(negedge clk);
        check("release_lvl", q_level, 0);
        send(8'hE0); send(8'h75);
        @(negedge clk);
        check("ext_make_lvl", q_level, 1);
        frame(u);
        check("ext_make_y", pos_y, 230);
        check("ext_make_x", pos_x, 330);

        do_reset();
        repeat (6) send(8'h6B);
        @(negedge clk);
        check("overflow_lvl", q_level, 4);
        check("overflow_drop", drop_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            frame(u);
            check($sformatf("drain%0d_upd", i), u, 1);
        end
        check("drain_x", pos_x, 280);
        check("drain_lvl", q_level, 0);
        frame(u);
        check("empty_tick_upd", u, 0);
        check("empty_tick_x", pos_x, 280);

        repeat (29) begin send(8'h74); @(negedge clk); frame(u); end
        check("walk_x", pos_x, 570);
        send(8'h74); send(8'h74);
        @(negedge clk);
        check("clamp_r_lvl", q_level, 2);
        frame(u);
        check("clamp_r1_upd", u, 1);
        check("clamp_r1_x", pos_x, 575);
        frame(u);
        check("clamp_r2_upd", u, 1);
        check("clamp_r2_x", pos_x, 575);
        repeat (24) begin send(8'h75); @(negedge clk); frame(u); end
        check("walk_up_y", pos_y, 0);
        send(8'h75); @(negedge clk); frame(u);
        check("clamp_up_upd", u, 1);
        check("clamp_up_y", pos_y, 0);
        repeat (43) begin send(8'h72); @(negedge clk); frame(u); end
        check("walk_down_y", pos_y, 430);
        send(8'h72); @(negedge clk); frame(u);
        check("clamp_d1_y", pos_y, 431);
        send(8'h72); @(negedge clk); frame(u);
        check("clamp_d2_upd", u, 1);
        check("clamp_d2_y", pos_y, 431);

        do_reset();
        repeat (4) send(8'h6B);
        @(negedge clk);
        check("full_lvl", q_level, 4);
        key = 8'h6B;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
        vs = 1'b0;
        @(negedge clk);
        check("pushpop_upd", upd, 1);
        check("pushpop_lvl", q_level, 4);
        check("pushpop_drop", drop_cnt, 0);
        check("pushpop_x", pos_x, 310);
        vs = 1'b1;
        @(negedge clk);
        repeat (4) frame(u);
        check("pushpop_drain_x", pos_x, 270);
        check("pushpop_drain_lvl", q_level, 0);

        do_reset();
        repeat (260) send(8'h6B);
        @(negedge clk);
        check("drop_sat", drop_cnt, 255);
        check("drop_sat_lvl", q_level, 4);

        do_reset();
        send(8'hF0);
        rst_n = 1'b0;
        #1;
        check("midrst_lvl", q_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h72);
        check("midrst_prepush_lvl", q_level, 0);
        @(negedge clk);
        check("midrst_push_lvl", q_level, 1);
        frame(u);
        check("midrst_upd", u, 1);
        check("midrst_y", pos_y, 250);
        check("midrst_x", pos_x, 320);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
